// File: rtl/hazard_detection_unit.sv
// ID-stage hazard unit: load-use / branch-operand stalls, taken-branch flush, halt-drain FSM.
// Optional saturating stall counter enabled by defining STALL_COUNTER_EN.
module hazard_detection_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned N_DRAIN    = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_rs_ifid,
  input  logic [REG_ADDR_W-1:0] i_rt_ifid,
  input  logic                  i_uses_rs,
  input  logic                  i_uses_rt,
  input  logic                  i_branch_id,
  input  logic                  i_halt_id,
  input  logic [REG_ADDR_W-1:0] i_rd_idex,
  input  logic                  i_reg_write_idex,
  input  logic                  i_mem_read_idex,
  input  logic [REG_ADDR_W-1:0] i_rd_exmem,
  input  logic                  i_mem_read_exmem,
  input  logic                  i_branch_taken,
  output logic                  o_stall_pc,
  output logic                  o_stall_ifid,
  output logic                  o_flush_idex,
  output logic                  o_flush_ifid,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  localparam int unsigned DW = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_drain;

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_load_use;
  logic w_br_ex;
  logic w_br_mem;
  logic w_stall;
  logic w_halt_go;

  // Register 0 is hardwired, so it never forms a dependency.
  assign w_hit_ex  = (i_rd_idex != '0) &&
                     (((i_rd_idex == i_rs_ifid) && i_uses_rs) ||
                      ((i_rd_idex == i_rt_ifid) && i_uses_rt));
  assign w_hit_mem = (i_rd_exmem != '0) &&
                     (((i_rd_exmem == i_rs_ifid) && i_uses_rs) ||
                      ((i_rd_exmem == i_rt_ifid) && i_uses_rt));

  assign w_load_use = i_mem_read_idex && i_reg_write_idex && w_hit_ex;
  assign w_br_ex    = i_branch_id && i_reg_write_idex && w_hit_ex;
  assign w_br_mem   = i_branch_id && i_mem_read_exmem && w_hit_mem;
  assign w_stall    = w_load_use | w_br_ex | w_br_mem;

  // A stall invalidates the branch/halt decode; branch outranks a (malformed) halt.
  assign w_halt_go  = !w_stall && !i_branch_taken && i_halt_id;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_drain <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_go) begin
            r_state <= ST_DRAIN;
            r_drain <= DW'(N_DRAIN - 1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_HALTED;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default: begin
          r_state <= ST_RUN;
          r_drain <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_stall_pc   = 1'b0;
    o_stall_ifid = 1'b0;
    o_flush_idex = 1'b0;
    o_flush_ifid = 1'b0;
    o_halted     = 1'b0;
    if (!i_reset) begin
      case (r_state)
        ST_RUN: begin
          if (w_stall) begin
            o_stall_pc   = 1'b1;
            o_stall_ifid = 1'b1;
            o_flush_idex = 1'b1;
          end else if (i_branch_taken) begin
            o_flush_ifid = 1'b1;
          end else if (i_halt_id) begin
            o_stall_pc   = 1'b1;
            o_stall_ifid = 1'b1;
          end
        end
        ST_DRAIN: begin
          o_stall_pc   = 1'b1;
          o_stall_ifid = 1'b1;
          o_flush_idex = 1'b1;
        end
        ST_HALTED: begin
          o_stall_pc   = 1'b1;
          o_stall_ifid = 1'b1;
          o_flush_idex = 1'b1;
          o_halted     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cycles = i_reset ? '0 : r_stall_cnt;
`else
  assign o_stall_cycles = '0;
`endif

endmodule
